// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
// Sequences the EHXPLLL: holds the PLL in reset, waits for LOCK, debounces it,
// retries on timeout and gates the reset of the PLL-clocked logic.
// Everything runs on the 100 MHz reference clock, which is valid before lock.
// Optional feature macro: PLL_SUP_LOSS_CNT_EN
//   defined   -> loss_cnt counts RUN->WAIT_LOCK transitions, saturating at 255
//   undefined -> loss_cnt is tied to zero and no counter flops are built
module pll_lock_supervisor #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int STABLE_CYCLES       = 1024,
  parameter int MAX_RETRIES         = 3,
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic          clk_100MHz,
  input  logic          rst_n,
  input  logic          pll_locked,
  input  logic          retry_req,
  output logic          pll_rst,
  output logic          sys_rst_n,
  output logic          ready,
  output logic          fail,
  output logic [RW-1:0] retry_cnt,
  output logic [7:0]    loss_cnt
);

  // The timer only has to reach the largest of the three cycle counts minus one.
  localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_CYC = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TW-1:0] RST_LAST     = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ONE    = TW'(1);
  localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);
  localparam logic [RW-1:0] RETRY_ONE    = RW'(1);

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAIL
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [1:0]    sync_q;
  logic          locked_s;

  // Two-flop synchronizer bringing the asynchronous LOCK pin into this domain.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
    end
  end

  assign locked_s = sync_q[1];

  // Sequencer: every output is updated on the same edge as the state it belongs to.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RESET_PLL;
      timer     <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      fail      <= 1'b0;
      retry_cnt <= '0;
    end else begin
      case (state)
        RESET_PLL: begin
          if (timer == RST_LAST) begin
            state   <= WAIT_LOCK;
            timer   <= '0;
            pll_rst <= 1'b0;
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state <= STABLE;
            timer <= '0;
          end else if (timer == TIMEOUT_LAST) begin
            timer <= '0;
            if (retry_cnt == RETRY_LIMIT) begin
              state <= FAIL;
              fail  <= 1'b1;
            end else begin
              state     <= RESET_PLL;
              pll_rst   <= 1'b1;
              retry_cnt <= retry_cnt + RETRY_ONE;
            end
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end
        STABLE: begin
          if (!locked_s) begin
            state <= WAIT_LOCK;
            timer <= '0;
          end else if (timer == STABLE_LAST) begin
            state     <= RUN;
            timer     <= '0;
            retry_cnt <= '0;
            sys_rst_n <= 1'b1;
            ready     <= 1'b1;
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state     <= WAIT_LOCK;
            timer     <= '0;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
          end
        end
        FAIL: begin
          if (retry_req) begin
            state     <= RESET_PLL;
            timer     <= '0;
            pll_rst   <= 1'b1;
            fail      <= 1'b0;
            retry_cnt <= '0;
          end
        end
        default: begin
          state     <= RESET_PLL;
          timer     <= '0;
          pll_rst   <= 1'b1;
          sys_rst_n <= 1'b0;
          ready     <= 1'b0;
          fail      <= 1'b0;
          retry_cnt <= '0;
        end
      endcase
    end
  end

`ifdef PLL_SUP_LOSS_CNT_EN
  // Saturating count of lock losses while running; only rst_n clears it.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt <= 8'd0;
    end else if ((state == RUN) && !locked_s && (loss_cnt != 8'hFF)) begin
      loss_cnt <= loss_cnt + 8'd1;
    end
  end
`else
  assign loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Testbench for pll_lock_supervisor with small cycle parameters.
// A reference model tracks the phase and the cycle at which it was entered,
// and every cycle the DUT outputs are compared against it.
module tb_pll_lock_supervisor;

   localparam int P_RST = 4;
   localparam int P_TO  = 16;
   localparam int P_ST  = 8;
   localparam int P_MAX = 2;

   logic       clk_100MHz = 1'b0;
   logic       rst_n;
   logic       pll_locked;
   logic       retry_req;
   logic       pll_rst;
   logic       sys_rst_n;
   logic       ready;
   logic       fail;
   logic [1:0] retry_cnt;
   logic [7:0] loss_cnt;

   int checkCount = 0;
   int errorCount = 0;

   // reference model state
   string ph;
   int    cyc = 0;
   int    since = 0;
   int    mRetry = 0;
   int    mLoss = 0;
   bit    pinHist[$];

   pll_lock_supervisor #(
      .PLL_RST_CYCLES(P_RST),
      .LOCK_TIMEOUT_CYCLES(P_TO),
      .STABLE_CYCLES(P_ST),
      .MAX_RETRIES(P_MAX)
   ) dut (
      .clk_100MHz(clk_100MHz),
      .rst_n(rst_n),
      .pll_locked(pll_locked),
      .retry_req(retry_req),
      .pll_rst(pll_rst),
      .sys_rst_n(sys_rst_n),
      .ready(ready),
      .fail(fail),
      .retry_cnt(retry_cnt),
      .loss_cnt(loss_cnt)
   );

   // 100 MHz reference clock
   always #5 clk_100MHz = ~clk_100MHz;

   // Hard stop in case something in the run refuses to terminate
   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int lossExp(input int n);
`ifdef PLL_SUP_LOSS_CNT_EN
      return (n > 255) ? 255 : n;
`else
      return 0;
`endif
   endfunction

   task automatic enterPhase(input string p);
      ph = p;
      since = cyc;
   endtask

   task automatic modelReset();
      ph = "RESET";
      since = cyc;
      mRetry = 0;
      mLoss = 0;
      pinHist.delete();
      pinHist.push_back(1'b0);
      pinHist.push_back(1'b0);
   endtask

   // One clock edge of the reference model; pinHist[0] is the pin as seen two edges ago
   task automatic modelEdge();
      bit ls;
      int el;
      cyc++;
      ls = pinHist[0];
      el = cyc - since;
      if (ph == "RESET") begin
         if (el == P_RST) enterPhase("WAIT");
      end else if (ph == "WAIT") begin
         if (ls) enterPhase("STABLE");
         else if (el == P_TO) begin
            if (mRetry == P_MAX) enterPhase("FAIL");
            else begin
               mRetry++;
               enterPhase("RESET");
            end
         end
      end else if (ph == "STABLE") begin
         if (!ls) enterPhase("WAIT");
         else if (el == P_ST) begin
            mRetry = 0;
            enterPhase("RUN");
         end
      end else if (ph == "RUN") begin
         if (!ls) begin
            mLoss = lossExp(mLoss + 1);
            enterPhase("WAIT");
         end
      end else if (ph == "FAIL") begin
         if (retry_req) begin
            mRetry = 0;
            enterPhase("RESET");
         end
      end
      void'(pinHist.pop_front());
      pinHist.push_back(pll_locked);
   endtask

   task automatic compareAll();
      checkOutput("pll_rst", 32'(pll_rst), 32'(ph == "RESET"));
      checkOutput("sys_rst_n", 32'(sys_rst_n), 32'(ph == "RUN"));
      checkOutput("ready", 32'(ready), 32'(ph == "RUN"));
      checkOutput("fail", 32'(fail), 32'(ph == "FAIL"));
      checkOutput("retry_cnt", 32'(retry_cnt), 32'(mRetry));
      checkOutput("loss_cnt", 32'(loss_cnt), 32'(mLoss));
   endtask

   // Advance one edge, update the model, then compare 1 ns later
   task automatic applyStimulus();
      @(posedge clk_100MHz);
      if (rst_n) modelEdge();
      #1;
      compareAll();
   endtask

   task automatic waitPhase(input string target, input int budget);
      bit found;
      found = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (ph == target) begin
            found = 1'b1;
            break;
         end
         applyStimulus();
      end
      if (ph == target) found = 1'b1;
      checkOutput({"reach_", target}, 32'(found), 32'd1);
   endtask

   task automatic assertReset();
      rst_n = 1'b0;
      modelReset();
      #1;
      compareAll();
      checkOutput("async_pll_rst", 32'(pll_rst), 32'd1);
      checkOutput("async_sys_rst_n", 32'(sys_rst_n), 32'd0);
      checkOutput("async_ready", 32'(ready), 32'd0);
      checkOutput("async_loss_cnt", 32'(loss_cnt), 32'd0);
      repeat (2) applyStimulus();
   endtask

   initial begin
      int cnt;
      int edges;
      int pulses;
      bit prev;
      bit seen;
      bit readySeen;
      bit found;
      int hold;

      rst_n = 1'b0;
      pll_locked = 1'b0;
      retry_req = 1'b0;
      modelReset();
      repeat (2) applyStimulus();

      // Normal bring-up: reset width and lock-to-ready latency
      rst_n = 1'b1;
      cnt = pll_rst ? 1 : 0;
      for (int i = 0; i < 20; i++) begin
         applyStimulus();
         if (!pll_rst) break;
         cnt++;
      end
      checkOutput("t1_rst_width", 32'(cnt), 32'd4);
      repeat (3) applyStimulus();
      pll_locked = 1'b1;
      edges = 0;
      for (int i = 1; i <= 30; i++) begin
         applyStimulus();
         if (ready) begin
            edges = i;
            break;
         end
      end
      checkOutput("t1_ready_latency", 32'(edges), 32'd11);
      checkOutput("t1_retry_cnt", 32'(retry_cnt), 32'd0);

      // Three lock losses while running
      for (int n = 0; n < 3; n++) begin
         pll_locked = 1'b0;
         seen = 1'b0;
         for (int i = 0; i < 3; i++) begin
            applyStimulus();
            if (!sys_rst_n) seen = 1'b1;
         end
         checkOutput("t4_sysrst_within3", 32'(seen), 32'd1);
         repeat (2) applyStimulus();
         pll_locked = 1'b1;
         seen = 1'b0;
         for (int i = 0; i < 40; i++) begin
            applyStimulus();
            if (pll_rst) seen = 1'b1;
            if (ready) break;
         end
         checkOutput("t4_ready_back", 32'(ready), 32'd1);
         checkOutput("t4_no_pll_rst", 32'(seen), 32'd0);
      end
      checkOutput("t4_loss_cnt", 32'(loss_cnt), 32'(lossExp(3)));

      // retry_req in RUN has no effect
      retry_req = 1'b1;
      applyStimulus();
      retry_req = 1'b0;
      applyStimulus();
      checkOutput("t5_run_ready", 32'(ready), 32'd1);
      checkOutput("t5_run_fail", 32'(fail), 32'd0);
      checkOutput("t5_run_pll_rst", 32'(pll_rst), 32'd0);

      // Async reset in RUN
      assertReset();

      // Lock never arrives: three pulses then FAIL
      pll_locked = 1'b0;
      rst_n = 1'b1;
      prev = pll_rst;
      pulses = pll_rst ? 1 : 0;
      for (int i = 0; i < 200; i++) begin
         applyStimulus();
         if (pll_rst && !prev) pulses++;
         prev = pll_rst;
         if (ph == "FAIL") break;
      end
      checkOutput("t2_reach_fail", 32'(ph == "FAIL"), 32'd1);
      for (int i = 0; i < 100; i++) begin
         applyStimulus();
         if (pll_rst && !prev) pulses++;
         prev = pll_rst;
      end
      checkOutput("t2_pulses", 32'(pulses), 32'd3);
      checkOutput("t2_fail", 32'(fail), 32'd1);
      checkOutput("t2_pll_rst", 32'(pll_rst), 32'd0);
      checkOutput("t2_retry_cnt", 32'(retry_cnt), 32'd2);

      // Leave FAIL via retry_req
      retry_req = 1'b1;
      applyStimulus();
      retry_req = 1'b0;
      checkOutput("t5_pll_rst", 32'(pll_rst), 32'd1);
      checkOutput("t5_retry_cnt", 32'(retry_cnt), 32'd0);
      checkOutput("t5_fail", 32'(fail), 32'd0);
      cnt = 1;
      for (int i = 0; i < 20; i++) begin
         applyStimulus();
         if (!pll_rst) break;
         cnt++;
      end
      checkOutput("t5_rst_width", 32'(cnt), 32'd4);

      // Glitch in STABLE after one retry has been used
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (ph == "WAIT" && mRetry == 1) begin
            found = 1'b1;
            break;
         end
         applyStimulus();
      end
      checkOutput("t3_one_retry", 32'(found), 32'd1);
      pll_locked = 1'b1;
      waitPhase("STABLE", 10);
      repeat (2) applyStimulus();
      pll_locked = 1'b0;
      readySeen = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus();
         if (ready) readySeen = 1'b1;
         if (pll_rst) seen = 1'b1;
      end
      checkOutput("t3_retry_kept", 32'(retry_cnt), 32'd1);
      pll_locked = 1'b1;
      edges = 0;
      for (int i = 1; i <= 30; i++) begin
         applyStimulus();
         if (pll_rst) seen = 1'b1;
         if (ready) begin
            edges = i;
            break;
         end
         if (ready) readySeen = 1'b1;
      end
      checkOutput("t3_ready_low", 32'(readySeen), 32'd0);
      checkOutput("t3_no_pll_rst", 32'(seen), 32'd0);
      checkOutput("t3_run_latency", 32'(edges), 32'd11);
      checkOutput("t3_retry_clear", 32'(retry_cnt), 32'd0);

      // Async reset in STABLE
      assertReset();
      rst_n = 1'b1;
      waitPhase("STABLE", 20);
      repeat (3) applyStimulus();
      assertReset();

      // Randomized lock behaviour with occasional retry requests
      rst_n = 1'b1;
      hold = 0;
      for (int i = 0; i < 1500; i++) begin
         if (hold == 0) begin
            pll_locked = ($urandom_range(0, 3) != 0);
            hold = $urandom_range(1, 30);
         end
         hold--;
         retry_req = ($urandom_range(0, 19) == 0);
         applyStimulus();
      end
      retry_req = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
